// File: rtl/vector_load_unit_if.sv
// rtl/vector_load_unit_if.sv - request, data-memory and register-file write bundle for vector_load_unit
//
// master : the load unit (drives busy/done, memory read port, register-file write port)
// slave  : the surrounding control path, memory and register file
//
// Signals: start/vd/base/stride (request), busy/done (status),
//          mem_re/mem_addr/mem_rdata (synchronous-read memory),
//          vrf_we/vrf_vd/vrf_wd (vector register file write port)
interface vector_load_unit_if #(
    parameter int NELEM = 5,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int RW    = 2
);
    logic                start;
    logic [RW-1:0]       vd;
    logic [AW-1:0]       base;
    logic [AW-1:0]       stride;
    logic                busy;
    logic                done;
    logic                mem_re;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_rdata;
    logic                vrf_we;
    logic [RW-1:0]       vrf_vd;
    logic [NELEM*DW-1:0] vrf_wd;

    modport master (
        input  start, vd, base, stride, mem_rdata,
        output busy, done, mem_re, mem_addr, vrf_we, vrf_vd, vrf_wd
    );

    modport slave (
        output start, vd, base, stride, mem_rdata,
        input  busy, done, mem_re, mem_addr, vrf_we, vrf_vd, vrf_wd
    );
endinterface

// File: rtl/vector_load_unit.sv
// rtl/vector_load_unit.sv - strided vector load: NELEM memory reads assembled into one register-file write
//
// Ports:
//   clk      system clock, all state on rising edge
//   reset_n  asynchronous active-low reset
//   bus      vector_load_unit_if.master: request (start/vd/base/stride), status (busy/done),
//            memory read port (mem_re/mem_addr/mem_rdata), register-file write port (vrf_we/vrf_vd/vrf_wd)
module vector_load_unit #(
    parameter int NELEM = 5,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int RW    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    vector_load_unit_if.master  bus
);
    localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NELEM - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WB} state_t;

    state_t              state;
    logic [RW-1:0]       vd_q;
    logic [AW-1:0]       stride_q;
    logic [IW-1:0]       idx;
    logic                pend;
    logic [IW-1:0]       cap_idx;
    logic [DW-1:0]       buffer  [NELEM];
    logic [DW-1:0]       buf_nxt [NELEM];
    logic [NELEM*DW-1:0] wd_nxt;

    logic                busy_q;
    logic                done_q;
    logic                mem_re_q;
    logic [AW-1:0]       mem_addr_q;
    logic                vrf_we_q;
    logic [RW-1:0]       vrf_vd_q;
    logic [NELEM*DW-1:0] vrf_wd_q;

    // Buffer contents as they will be after this edge. The last element lands
    // on the same edge that loads vrf_wd, so the write vector is taken from
    // this view rather than from the registered buffer.
    always_comb begin
        buf_nxt = buffer;
        if (pend) begin
            buf_nxt[cap_idx] = bus.mem_rdata;
        end
        wd_nxt = '0;
        for (int i = 0; i < NELEM; i++) begin
            wd_nxt[i*DW +: DW] = buf_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            vd_q       <= '0;
            stride_q   <= '0;
            idx        <= '0;
            pend       <= 1'b0;
            cap_idx    <= '0;
            for (int i = 0; i < NELEM; i++) begin
                buffer[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            vrf_we_q   <= 1'b0;
            vrf_vd_q   <= '0;
            vrf_wd_q   <= '0;
        end else begin
            // Capture path is state-independent: a read issued this cycle is
            // written into the buffer one cycle later, whatever the state.
            pend   <= 1'b0;
            buffer <= buf_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        vd_q       <= bus.vd;
                        stride_q   <= bus.stride;
                        mem_addr_q <= bus.base;
                        idx        <= '0;
                        mem_re_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    pend    <= 1'b1;
                    cap_idx <= idx;
                    if (idx == LAST_IDX) begin
                        // mem_addr is left on the last issued address
                        mem_re_q <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        mem_addr_q <= mem_addr_q + stride_q;
                        idx        <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    vrf_we_q <= 1'b1;
                    done_q   <= 1'b1;
                    vrf_vd_q <= vd_q;
                    vrf_wd_q <= wd_nxt;
                    state    <= WB;
                end
                WB: begin
                    vrf_we_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.vrf_we   = vrf_we_q;
    assign bus.vrf_vd   = vrf_vd_q;
    assign bus.vrf_wd   = vrf_wd_q;
endmodule

// File: tb/tb_vector_load_unit.sv
// tb/tb_vector_load_unit.sv - directed self-checking bench for vector_load_unit
module tb_vector_load_unit;
    localparam int NELEM = 5;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int RW    = 2;

    logic clk;
    logic reset_n;
    bit   dead_mode;

    int tests_run;
    int tests_failed;
    int cyc;
    int we_count;
    int we_cyc [64];

    logic [RW-1:0]       exp_vd;
    logic [NELEM*DW-1:0] exp_wd;

    vector_load_unit_if #(.NELEM(NELEM), .DW(DW), .AW(AW), .RW(RW)) bus ();

    vector_load_unit #(.NELEM(NELEM), .DW(DW), .AW(AW), .RW(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for a read appears the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= dead_mode ? 32'hDEADBEEF : (bus.mem_addr ^ 32'hA5A50000);
        end
    end

    always @(posedge clk) begin
        if (bus.vrf_we) begin
            if (we_count < 64) we_cyc[we_count] = cyc;
            we_count++;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [NELEM*DW-1:0] got, input logic [NELEM*DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NELEM*DW-1:0] wd_from_addr(input logic [NELEM*32-1:0] eaddr, input bit dead);
        logic [NELEM*DW-1:0] w;
        for (int k = 0; k < NELEM; k++) begin
            w[k*DW +: DW] = dead ? 32'hDEADBEEF : (eaddr[k*32 +: 32] ^ 32'hA5A50000);
        end
        return w;
    endfunction

    // Starts a load at the current negedge (cycle c0) and checks c1..c7.
    // Returns at the c7 (WB) negedge.
    task automatic run_load(input logic [RW-1:0] vd_i, input logic [31:0] base_i,
                            input logic [31:0] stride_i, input logic [NELEM*32-1:0] eaddr,
                            input bit dead);
        logic [NELEM*DW-1:0] ewd;
        ewd = wd_from_addr(eaddr, dead);
        bus.start  = 1'b1;
        bus.vd     = vd_i;
        bus.base   = base_i;
        bus.stride = stride_i;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < NELEM; k++) begin
            check($sformatf("issue%0d_busy", k), bus.busy, 1);
            check($sformatf("issue%0d_mem_re", k), bus.mem_re, 1);
            check($sformatf("issue%0d_addr", k), bus.mem_addr, eaddr[k*32 +: 32]);
            check($sformatf("issue%0d_vd_hold", k), bus.vrf_vd, exp_vd);
            check($sformatf("issue%0d_we", k), bus.vrf_we, 0);
            @(negedge clk);
        end
        check("drain_mem_re", bus.mem_re, 0);
        check("drain_busy", bus.busy, 1);
        check("drain_we", bus.vrf_we, 0);
        check("drain_wd_hold", bus.vrf_wd, exp_wd);
        @(negedge clk);
        check("wb_we", bus.vrf_we, 1);
        check("wb_done", bus.done, 1);
        check("wb_busy", bus.busy, 1);
        check("wb_vd", bus.vrf_vd, vd_i);
        check("wb_wd", bus.vrf_wd, ewd);
        check("wb_addr_hold", bus.mem_addr, eaddr[(NELEM-1)*32 +: 32]);
        exp_vd = vd_i;
        exp_wd = ewd;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_we"}, bus.vrf_we, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_mem_re"}, bus.mem_re, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle(tag);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_vd"}, bus.vrf_vd, 0);
        check({tag, "_wd"}, bus.vrf_wd, 0);
    endtask

    initial begin
        int c0;
        int wb;
        tests_run     = 0;
        tests_failed  = 0;
        cyc           = 0;
        we_count      = 0;
        dead_mode     = 1'b0;
        exp_vd        = '0;
        exp_wd        = '0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.vd        = '0;
        bus.base      = '0;
        bus.stride    = '0;
        bus.mem_rdata = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Positive stride
        run_load(2'd2, 32'h100, 32'h4,
                 {32'h110, 32'h10C, 32'h108, 32'h104, 32'h100}, 1'b0);
        @(negedge clk);
        check_idle("t1_c8");

        // Negative stride wrapping through zero
        run_load(2'd1, 32'h8, 32'hFFFFFFFC,
                 {32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8}, 1'b0);
        @(negedge clk);
        check_idle("t2_c8");

        // Stride zero, constant memory word
        dead_mode = 1'b1;
        run_load(2'd3, 32'h40, 32'h0,
                 {32'h40, 32'h40, 32'h40, 32'h40, 32'h40}, 1'b1);
        @(negedge clk);
        check_idle("t3_c8");
        dead_mode = 1'b0;

        // start held high: accepts at E0 and E8 only
        c0 = cyc;
        wb = we_count;
        bus.start  = 1'b1;
        bus.vd     = 2'd2;
        bus.base   = 32'h500;
        bus.stride = 32'h4;
        repeat (16) @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("held_we_pulses", we_count - wb, 2);
        if (we_count - wb >= 2 && wb + 1 < 64) begin
            check("held_first_we_cycle", we_cyc[wb] - c0, 7);
            check("held_second_we_cycle", we_cyc[wb+1] - c0, 15);
        end
        check("held_vd", bus.vrf_vd, 2);
        exp_vd = 2'd2;
        exp_wd = wd_from_addr({32'h510, 32'h50C, 32'h508, 32'h504, 32'h500}, 1'b0);
        check("held_wd", bus.vrf_wd, exp_wd);

        // start during WB is ignored
        run_load(2'd0, 32'h700, 32'h8,
                 {32'h720, 32'h718, 32'h710, 32'h708, 32'h700}, 1'b0);
        wb = we_count;
        bus.start = 1'b1;
        bus.vd    = 2'd1;
        bus.base  = 32'h600;
        @(negedge clk);
        bus.start = 1'b0;
        check_idle("wbign_c8");
        @(negedge clk);
        check_idle("wbign_c9");
        repeat (10) @(negedge clk);
        check("wbign_no_we", we_count - wb, 1);
        check("wbign_vd_hold", bus.vrf_vd, exp_vd);

        // Reset in c4 aborts the load
        bus.start  = 1'b1;
        bus.vd     = 2'd3;
        bus.base   = 32'h200;
        bus.stride = 32'h8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_pre_addr", bus.mem_addr, 32'h218);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_vd = '0;
        exp_wd = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wb = we_count;
        repeat (10) @(negedge clk);
        check("midrst_no_we", we_count - wb, 0);
        check("midrst_wd_zero", bus.vrf_wd, 0);
        run_load(2'd1, 32'h300, 32'h4,
                 {32'h310, 32'h30C, 32'h308, 32'h304, 32'h300}, 1'b0);
        @(negedge clk);
        check_idle("midrst_reload_c8");

        // Back-to-back loads: busy low for exactly c8
        run_load(2'd0, 32'h1000, 32'h4,
                 {32'h1010, 32'h100C, 32'h1008, 32'h1004, 32'h1000}, 1'b0);
        @(negedge clk);
        check_idle("b2b_gap");
        check("b2b_gap_vd", bus.vrf_vd, 0);
        run_load(2'd3, 32'h2000, 32'h10,
                 {32'h2040, 32'h2030, 32'h2020, 32'h2010, 32'h2000}, 1'b0);
        @(negedge clk);
        check_idle("b2b_end");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
